arm_cortex_m0_pipelined_shifter: RTL and testbench



---
 rtl/arm_m0_shifter_pkg.sv | 38 +++
 rtl/arm_m0_shift_stage.sv | 88 ++++++++
 rtl/arm_cortex_m0_pipelined_shifter.sv | 161 ++++++++++++++++
 tb/tb_arm_cortex_m0_pipelined_shifter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_m0_shifter_pkg.sv
// ---------------------------------------------------------------------------
// arm_m0_shifter_pkg
//   Shared definitions for the pipelined M0 shifter: external opcode
//   encodings, the internal shift-kind enum carried down the pipe, and
//   small decode helpers used by stage 0.
// ---------------------------------------------------------------------------
package arm_m0_shifter_pkg;

    localparam logic [3:0] OP_LSL = 4'b1010;
    localparam logic [3:0] OP_LSR = 4'b1011;
    localparam logic [3:0] OP_ASR = 4'b1100;
    localparam logic [3:0] OP_ROR = 4'b1101;

    // Shift kind as seen by the log-shifter stages. Pass-through operations
    // travel as SH_LSL with a zero effective amount, so no stage touches them.
    typedef enum logic [1:0] {
        SH_LSL = 2'd0,
        SH_LSR = 2'd1,
        SH_ASR = 2'd2,
        SH_ROR = 2'd3
    } shop_e;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_LSL) || (op == OP_LSR) || (op == OP_ASR) || (op == OP_ROR);
    endfunction

    function automatic shop_e decode_op(input logic [3:0] op);
        shop_e k;
        case (op)
            OP_LSR:  k = SH_LSR;
            OP_ASR:  k = SH_ASR;
            OP_ROR:  k = SH_ROR;
            default: k = SH_LSL;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/arm_m0_shift_stage.sv
// ---------------------------------------------------------------------------
// arm_m0_shift_stage
//   One stage of the logarithmic shifter: conditionally shifts/rotates the
//   operand by K (when bit log2(K) of the effective amount is set), updates
//   the carry, and registers the whole operation when the pipe advances.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   adv                 pipeline advance enable (shared by all stages)
//   in_*                operation from the previous stage
//   out_*               registered operation to the next stage
// ---------------------------------------------------------------------------
module arm_m0_shift_stage
    import arm_m0_shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHIFT = 5,
    parameter int TAG_W = 4,
    parameter int K     = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             adv,
    input  logic             in_valid,
    input  shop_e            in_op,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_carry,
    input  logic [SHIFT-1:0] in_eff,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output shop_e            out_op,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic [SHIFT-1:0] out_eff,
    output logic [TAG_W-1:0] out_tag
);

    localparam int B = $clog2(K);

    logic [WIDTH-1:0] d_sh;
    logic             c_sh;

    always_comb begin
        d_sh = in_data;
        c_sh = in_carry;
        if (in_eff[B]) begin
            case (in_op)
                SH_LSL: begin
                    d_sh = in_data << K;
                    c_sh = in_data[WIDTH-K];
                end
                SH_LSR: begin
                    d_sh = in_data >> K;
                    c_sh = in_data[K-1];
                end
                SH_ASR: begin
                    d_sh = $signed(in_data) >>> K;
                    c_sh = in_data[K-1];
                end
                SH_ROR: begin
                    // bit K-1 becomes the new MSB, which is also the carry
                    d_sh = {in_data[K-1:0], in_data[WIDTH-1:K]};
                    c_sh = in_data[K-1];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_op    <= SH_LSL;
            out_data  <= '0;
            out_carry <= 1'b0;
            out_eff   <= '0;
            out_tag   <= '0;
        end else if (adv) begin
            out_valid <= in_valid;
            out_op    <= in_op;
            out_data  <= d_sh;
            out_carry <= c_sh;
            out_eff   <= in_eff;
            out_tag   <= in_tag;
        end
    end

endmodule

// File: rtl/arm_cortex_m0_pipelined_shifter.sv
// ---------------------------------------------------------------------------
// arm_cortex_m0_pipelined_shifter
//   Pipelined barrel shifter (LSL/LSR/ASR/ROR) with ARM-style carry-out,
//   saturation for large amounts, valid/ready handshake and a tag that
//   travels with each operation. Stage 0 decodes and saturates; SHIFT
//   log-shifter stages follow. All stages advance together.
//
// Ports
//   clk, reset                   clock, synchronous active-high reset
//   in_valid/in_ready            input handshake
//   in_opcode, in_data,
//   in_amount, in_carry, in_tag  operation
//   out_valid/out_ready          output handshake
//   out_data, out_carry, out_tag result
// ---------------------------------------------------------------------------
module arm_cortex_m0_pipelined_shifter
    import arm_m0_shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHIFT = 5,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_opcode,
    input  logic [WIDTH-1:0] in_data,
    input  logic [7:0]       in_amount,
    input  logic             in_carry,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic [TAG_W-1:0] out_tag
);

    typedef struct packed {
        logic             valid;
        shop_e            op;
        logic [WIDTH-1:0] data;
        logic             carry;
        logic [SHIFT-1:0] eff_amt;
        logic [TAG_W-1:0] tag;
    } stage_t;

    stage_t           s0_nxt;
    logic [31:0]      amt;

    logic             st_valid [0:SHIFT];
    shop_e            st_op    [0:SHIFT];
    logic [WIDTH-1:0] st_data  [0:SHIFT];
    logic             st_carry [0:SHIFT];
    logic [SHIFT-1:0] st_eff   [0:SHIFT];
    logic [TAG_W-1:0] st_tag   [0:SHIFT];

    logic             adv;

    // No bubble collapsing: the whole pipe freezes while the result is held.
    assign adv      = !st_valid[SHIFT] || out_ready;
    assign in_ready = adv;

    assign amt = {24'd0, in_amount};

    // Stage 0: resolve amount 0, pass-through and out-of-range amounts here
    // so the shift stages only ever see an amount below WIDTH.
    always_comb begin
        s0_nxt         = '0;
        s0_nxt.valid   = in_valid;
        s0_nxt.op      = decode_op(in_opcode);
        s0_nxt.data    = in_data;
        s0_nxt.carry   = in_carry;
        s0_nxt.eff_amt = '0;
        s0_nxt.tag     = in_tag;
        if (is_shift_op(in_opcode) && (in_amount != 8'd0)) begin
            case (s0_nxt.op)
                SH_LSL, SH_LSR: begin
                    if (amt == WIDTH) begin
                        s0_nxt.data  = '0;
                        s0_nxt.carry = (s0_nxt.op == SH_LSL) ? in_data[WIDTH-1] : in_data[0];
                    end else if (amt > WIDTH) begin
                        s0_nxt.data  = '0;
                        s0_nxt.carry = 1'b0;
                    end else begin
                        s0_nxt.eff_amt = in_amount[SHIFT-1:0];
                    end
                end
                SH_ASR: begin
                    if (amt >= WIDTH) begin
                        s0_nxt.data  = {WIDTH{in_data[WIDTH-1]}};
                        s0_nxt.carry = in_data[WIDTH-1];
                    end else begin
                        s0_nxt.eff_amt = in_amount[SHIFT-1:0];
                    end
                end
                SH_ROR: begin
                    // full-turn rotation: data unchanged, carry is the MSB
                    s0_nxt.eff_amt = in_amount[SHIFT-1:0];
                    if (in_amount[SHIFT-1:0] == '0) begin
                        s0_nxt.carry = in_data[WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_valid[0] <= 1'b0;
            st_op[0]    <= SH_LSL;
            st_data[0]  <= '0;
            st_carry[0] <= 1'b0;
            st_eff[0]   <= '0;
            st_tag[0]   <= '0;
        end else if (adv) begin
            st_valid[0] <= s0_nxt.valid;
            st_op[0]    <= s0_nxt.op;
            st_data[0]  <= s0_nxt.data;
            st_carry[0] <= s0_nxt.carry;
            st_eff[0]   <= s0_nxt.eff_amt;
            st_tag[0]   <= s0_nxt.tag;
        end
    end

    for (genvar i = 0; i < SHIFT; i++) begin : g_stage
        arm_m0_shift_stage #(
            .WIDTH (WIDTH),
            .SHIFT (SHIFT),
            .TAG_W (TAG_W),
            .K     (1 << i)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .adv       (adv),
            .in_valid  (st_valid[i]),
            .in_op     (st_op[i]),
            .in_data   (st_data[i]),
            .in_carry  (st_carry[i]),
            .in_eff    (st_eff[i]),
            .in_tag    (st_tag[i]),
            .out_valid (st_valid[i+1]),
            .out_op    (st_op[i+1]),
            .out_data  (st_data[i+1]),
            .out_carry (st_carry[i+1]),
            .out_eff   (st_eff[i+1]),
            .out_tag   (st_tag[i+1])
        );
    end

    assign out_valid = st_valid[SHIFT];
    assign out_data  = st_data[SHIFT];
    assign out_carry = st_carry[SHIFT];
    assign out_tag   = st_tag[SHIFT];

    // shift kind and amount are spent once they leave the last stage
    logic unused_last;
    assign unused_last = ^{st_op[SHIFT], st_eff[SHIFT]};

endmodule

// File: tb/tb_arm_cortex_m0_pipelined_shifter.sv
module tb_arm_cortex_m0_pipelined_shifter;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_carry;
    logic [3:0]  in_opcode, in_tag;
    logic [31:0] in_data;
    logic [7:0]  in_amount;
    logic        out_valid, out_ready, out_carry;
    logic [31:0] out_data;
    logic [3:0]  out_tag;

    always #5 clk = ~clk;

    arm_cortex_m0_pipelined_shifter #(.WIDTH(32), .SHIFT(5), .TAG_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_data   (in_data),
        .in_amount (in_amount),
        .in_carry  (in_carry),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_tag   (out_tag)
    );

    typedef struct {
        logic [31:0] d;
        logic        c;
        logic [3:0]  t;
    } exp_t;

    exp_t        q[$];
    exp_t        pending;
    int          ncomp = 0;
    int          nfail = 0;
    bit          acc;
    bit          prev_stall;
    logic [31:0] prev_d;
    logic        prev_c;
    logic [3:0]  prev_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model of the shifter behaviour, bit-serial.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] din,
                                   input logic [7:0] a, input logic cin, input logic [3:0] t);
        exp_t        r;
        logic [31:0] d = din;
        logic        c = cin;
        int          n = int'(a);
        if (n != 0) begin
            case (op)
                4'b1010: begin
                    if (n == 32)     begin c = din[31]; d = '0; end
                    else if (n > 32) begin c = 1'b0;    d = '0; end
                    else repeat (n)  begin c = d[31]; d = {d[30:0], 1'b0}; end
                end
                4'b1011: begin
                    if (n == 32)     begin c = din[0]; d = '0; end
                    else if (n > 32) begin c = 1'b0;   d = '0; end
                    else repeat (n)  begin c = d[0]; d = {1'b0, d[31:1]}; end
                end
                4'b1100: begin
                    if (n >= 32)    begin c = din[31]; d = {32{din[31]}}; end
                    else repeat (n) begin c = d[0]; d = {d[31], d[31:1]}; end
                end
                4'b1101: begin
                    repeat (n % 32) d = {d[0], d[31:1]};
                    c = d[31];
                end
                default: ;
            endcase
        end
        r.d = d; r.c = c; r.t = t;
        return r;
    endfunction

    // One clock: inputs are already set; sample at negedge+1, then advance.
    task automatic step();
        exp_t e;
        #1;
        acc = 1'b0;
        if (!reset) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
            if (prev_stall) begin
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_data", out_data, prev_d);
                chk("stall_carry", {31'd0, out_carry}, {31'd0, prev_c});
                chk("stall_tag", {28'd0, out_tag}, {28'd0, prev_t});
            end
            if (in_valid && in_ready) begin
                q.push_back(pending);
                acc = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("out_extra", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_carry", {31'd0, out_carry}, {31'd0, e.c});
                    chk("out_tag", {28'd0, out_tag}, {28'd0, e.t});
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_d = out_data;
            prev_c = out_carry;
            prev_t = out_tag;
        end else begin
            prev_stall = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(input logic [3:0] op, input logic [31:0] d, input logic [7:0] a,
                          input logic c, input logic [3:0] t);
        in_valid  = 1'b1;
        in_opcode = op;
        in_data   = d;
        in_amount = a;
        in_carry  = c;
        in_tag    = t;
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] d, input logic [7:0] a,
                        input logic c, input logic [3:0] t,
                        input logic [31:0] ed, input logic ec);
        set_in(op, d, a, c, t);
        pending.d = ed; pending.c = ec; pending.t = t;
        for (int i = 0; i < 50; i++) begin
            step();
            if (acc) break;
        end
        if (!acc) chk("accept_timeout", {31'd0, acc}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (q.size() == 0) break;
            step();
        end
        chk("drain_left", q.size(), 32'd0);
    endtask

    logic [3:0] r_op  [10];
    logic [31:0] r_d  [10];
    logic [7:0] r_a   [10];
    logic       r_c   [10];

    initial begin
        int          lat;
        int          issued;
        int          cyc;
        bit          pat [4];
        logic [3:0]  ops [6];
        logic [7:0]  amts [8];
        exp_t        m;

        pat  = '{1'b1, 1'b0, 1'b0, 1'b1};
        ops  = '{4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b0000, 4'b1111};
        amts = '{8'd0, 8'd1, 8'd31, 8'd32, 8'd33, 8'd64, 8'd200, 8'd13};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_opcode = '0; in_data = '0; in_amount = '0; in_carry = 1'b0; in_tag = '0;
        prev_stall = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_carry", {31'd0, out_carry}, 32'd0);
        chk("rst_out_tag", {28'd0, out_tag}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        // latency of a single LSL
        set_in(4'b1010, 32'h0000_0001, 8'd4, 1'b0, 4'd5);
        pending.d = 32'h10; pending.c = 1'b0; pending.t = 4'd5;
        step();
        if (!acc) chk("accept_timeout", {31'd0, acc}, 32'd1);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("latency", lat, 32'd6);
        drain();

        // directed vectors, issued back to back
        send(4'b1011, 32'h8000_0003, 8'd1,  1'b0, 4'd1, 32'h4000_0001, 1'b1);
        send(4'b1100, 32'h8000_0000, 8'd40, 1'b0, 4'd2, 32'hFFFF_FFFF, 1'b1);
        send(4'b1010, 32'h8000_0000, 8'd32, 1'b0, 4'd3, 32'h0000_0000, 1'b1);
        send(4'b1010, 32'hFFFF_FFFF, 8'd33, 1'b1, 4'd4, 32'h0000_0000, 1'b0);
        send(4'b1011, 32'h0000_0001, 8'd32, 1'b0, 4'd5, 32'h0000_0000, 1'b1);
        send(4'b1010, 32'h1234_5678, 8'd0,  1'b1, 4'd6, 32'h1234_5678, 1'b1);
        send(4'b1101, 32'hA5A5_A5A5, 8'd0,  1'b0, 4'd7, 32'hA5A5_A5A5, 1'b0);
        send(4'b1100, 32'h8000_0000, 8'd0,  1'b1, 4'd8, 32'h8000_0000, 1'b1);
        send(4'b1101, 32'h0000_0001, 8'd1,  1'b0, 4'd9, 32'h8000_0000, 1'b1);
        send(4'b1101, 32'hF000_000F, 8'd64, 1'b0, 4'd10, 32'hF000_000F, 1'b1);
        send(4'b0000, 32'hDEAD_BEEF, 8'd7,  1'b1, 4'd11, 32'hDEAD_BEEF, 1'b1);
        send(4'b1111, 32'h0F0F_0F0F, 8'd3,  1'b0, 4'd12, 32'h0F0F_0F0F, 1'b0);
        send(4'b1010, 32'h0000_0001, 8'd31, 1'b1, 4'd13, 32'h8000_0000, 1'b0);
        send(4'b1100, 32'h4000_0000, 8'd31, 1'b0, 4'd14, 32'h0000_0000, 1'b1);
        send(4'b1011, 32'h8000_0000, 8'd31, 1'b1, 4'd15, 32'h0000_0001, 1'b0);
        send(4'b1101, 32'h1234_5678, 8'd36, 1'b0, 4'd0, 32'h8123_4567, 1'b1);
        send(4'b1100, 32'h8000_0000, 8'd32, 1'b0, 4'd1, 32'hFFFF_FFFF, 1'b1);
        drain();

        // back-to-back with out_ready pattern 1,0,0,1
        for (int i = 0; i < 10; i++) begin
            r_op[i] = ops[$urandom_range(0, 5)];
            r_d[i]  = $urandom;
            r_a[i]  = (i % 3 == 2) ? 8'($urandom_range(0, 255)) : amts[$urandom_range(0, 7)];
            r_c[i]  = 1'($urandom_range(0, 1));
        end
        issued = 0;
        cyc = 0;
        while ((issued < 10 || q.size() != 0) && cyc < 400) begin
            out_ready = pat[cyc % 4];
            if (issued < 10) begin
                set_in(r_op[issued], r_d[issued], r_a[issued], r_c[issued], 4'(issued));
                m = model(r_op[issued], r_d[issued], r_a[issued], r_c[issued], 4'(issued));
                pending = m;
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (acc) issued++;
            cyc++;
        end
        in_valid = 1'b0;
        chk("b2b_issued", issued, 32'd10);
        chk("b2b_left", q.size(), 32'd0);
        out_ready = 1'b1;
        step();

        // reset with operations in flight
        out_ready = 1'b0;
        send(4'b1010, 32'h0000_00FF, 8'd2, 1'b0, 4'd3, 32'h0000_03FC, 1'b0);
        send(4'b1011, 32'h0000_00FF, 8'd2, 1'b0, 4'd4, 32'h0000_003F, 1'b1);
        send(4'b1101, 32'h0000_00FF, 8'd4, 1'b0, 4'd5, 32'hF000_000F, 1'b1);
        step();
        step();
        reset = 1'b1;
        step();
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        q.delete();
        reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("post_reset_quiet", {31'd0, out_valid}, 32'd0);
        end
        send(4'b1010, 32'h0000_0003, 8'd1, 1'b1, 4'd9, 32'h0000_0006, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
